// File: rtl/dice_race_pkg.sv
// Shared types for the dice-race datapath: detector colour codes, roll FSM states
// and the colour-to-steps mapping.
package dice_race_pkg;

   typedef enum logic [1:0] {
      COLOR_NONE  = 2'd0,
      COLOR_RED   = 2'd1,
      COLOR_GREEN = 2'd2,
      COLOR_BLUE  = 2'd3
   } color_t;

   typedef enum logic [1:0] {
      S_ARMED      = 2'd0,
      S_CONFIRM    = 2'd1,
      S_ISSUE      = 2'd2,
      S_WAIT_CLEAR = 2'd3
   } roll_state_t;

   function automatic logic [1:0] color_to_steps(input color_t c);
      logic [1:0] steps;
      case (c)
         COLOR_RED:   steps = 2'd1;
         COLOR_GREEN: steps = 2'd2;
         COLOR_BLUE:  steps = 2'd3;
         default:     steps = 2'd0;
      endcase
      return steps;
   endfunction

endpackage

// File: rtl/dice_roll_controller.sv
// Debounces the filtered colour stream into one valid/ready move command per card,
// re-arms only once the card has left the ROI, and rotates the active player.
module dice_roll_controller
   import dice_race_pkg::*;
#(
   parameter int unsigned CONFIRM_COUNT = 4,
   parameter int unsigned CLEAR_COUNT   = 3,
   parameter int unsigned NUM_PLAYERS   = 2,
   localparam int unsigned PW = $clog2(NUM_PLAYERS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          new_game,
   input  logic          roll_enable,
   input  logic [1:0]    stable_color,
   input  logic          result_ready,
   output logic          move_valid,
   input  logic          move_ready,
   output logic [1:0]    move_steps,
   output logic [PW-1:0] move_player,
   output logic          armed,
   output logic [1:0]    dbg_state
);

   localparam int unsigned CW = $clog2(CONFIRM_COUNT + 1);
   localparam int unsigned LW = $clog2(CLEAR_COUNT + 1);

   roll_state_t   state_q;
   color_t        cand_q;
   logic [CW-1:0] cnt_q;
   logic [LW-1:0] clr_q;
   logic [PW-1:0] player_q;
   logic [PW-1:0] player_d;
   logic          valid_q;
   logic [1:0]    steps_q;
   logic [PW-1:0] mplayer_q;
   logic          armed_q;

   color_t        color_in;
   logic          color_hit;
   logic [CW-1:0] cnt_inc;
   logic [LW-1:0] clr_inc;

   assign color_in  = color_t'(stable_color);
   assign color_hit = result_ready && (color_in != COLOR_NONE);
   assign cnt_inc   = cnt_q + CW'(1);
   assign clr_inc   = clr_q + LW'(1);
   // Wrap compare at the last player so non-power-of-2 player counts rotate correctly
   assign player_d  = (player_q == PW'(NUM_PLAYERS - 1)) ? '0 : player_q + PW'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_ARMED;
         cand_q    <= COLOR_NONE;
         cnt_q     <= '0;
         clr_q     <= '0;
         player_q  <= '0;
         valid_q   <= 1'b0;
         steps_q   <= 2'd0;
         mplayer_q <= '0;
         armed_q   <= 1'b1;
      end else if (new_game) begin
         // Also discards a transfer completing on this edge
         state_q   <= S_ARMED;
         cand_q    <= COLOR_NONE;
         cnt_q     <= '0;
         clr_q     <= '0;
         player_q  <= '0;
         valid_q   <= 1'b0;
         steps_q   <= 2'd0;
         mplayer_q <= '0;
         armed_q   <= 1'b1;
      end else begin
         case (state_q)
            S_ARMED: begin
               if (color_hit && roll_enable) begin
                  cand_q  <= color_in;
                  cnt_q   <= CW'(1);
                  armed_q <= 1'b0;
                  if (CONFIRM_COUNT == 1) begin
                     state_q   <= S_ISSUE;
                     valid_q   <= 1'b1;
                     steps_q   <= color_to_steps(color_in);
                     mplayer_q <= player_q;
                  end else begin
                     state_q <= S_CONFIRM;
                  end
               end
            end
            S_CONFIRM: begin
               if (!roll_enable || (result_ready && color_in == COLOR_NONE)) begin
                  state_q <= S_ARMED;
                  cnt_q   <= '0;
                  armed_q <= 1'b1;
               end else if (result_ready) begin
                  if (color_in == cand_q) begin
                     cnt_q <= cnt_inc;
                     if (cnt_inc == CW'(CONFIRM_COUNT)) begin
                        state_q   <= S_ISSUE;
                        valid_q   <= 1'b1;
                        steps_q   <= color_to_steps(cand_q);
                        mplayer_q <= player_q;
                     end
                  end else begin
                     cand_q <= color_in;
                     cnt_q  <= CW'(1);
                  end
               end
            end
            S_ISSUE: begin
               if (move_ready) begin
                  state_q  <= S_WAIT_CLEAR;
                  valid_q  <= 1'b0;
                  steps_q  <= 2'd0;
                  player_q <= player_d;
                  cnt_q    <= '0;
                  clr_q    <= '0;
               end
            end
            S_WAIT_CLEAR: begin
               if (result_ready) begin
                  if (color_in != COLOR_NONE) begin
                     clr_q <= '0;
                  end else if (clr_inc == LW'(CLEAR_COUNT)) begin
                     state_q <= S_ARMED;
                     clr_q   <= '0;
                     armed_q <= 1'b1;
                  end else begin
                     clr_q <= clr_inc;
                  end
               end
            end
            default: begin
               state_q <= S_ARMED;
               armed_q <= 1'b1;
            end
         endcase
      end
   end

   assign move_valid  = valid_q;
   assign move_steps  = steps_q;
   assign move_player = mplayer_q;
   assign armed       = armed_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_dice_roll_controller.sv
// Self-checking bench: run-length model of the roll debouncer compared every cycle,
// plus directed scenarios with literal expectations.
module tb_dice_roll_controller;
   import dice_race_pkg::*;

   localparam int CONF = 4;
   localparam int CLR  = 3;
   localparam int NP   = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       new_game = 1'b0;
   logic       roll_enable = 1'b1;
   logic [1:0] stable_color = 2'd0;
   logic       result_ready = 1'b0;
   logic       move_ready = 1'b1;
   logic       move_valid;
   logic [1:0] move_steps;
   logic [0:0] move_player;
   logic       armed;
   logic [1:0] dbg_state;

   int total = 0;
   int bad   = 0;
   int xfers = 0;

   always #5 clk = ~clk;

   dice_roll_controller #(
      .CONFIRM_COUNT(CONF),
      .CLEAR_COUNT  (CLR),
      .NUM_PLAYERS  (NP)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .new_game    (new_game),
      .roll_enable (roll_enable),
      .stable_color(stable_color),
      .result_ready(result_ready),
      .move_valid  (move_valid),
      .move_ready  (move_ready),
      .move_steps  (move_steps),
      .move_player (move_player),
      .armed       (armed),
      .dbg_state   (dbg_state)
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a move is owed once the same colour has been seen CONF times in a row
   // since arming; after a move, CLR NONE results in a row are needed to re-arm.
   typedef struct packed {
      bit pend;
      bit clearing;
      int run_col;
      int run_len;
      int none_run;
      int player;
      int steps;
   } mdl_t;

   mdl_t m;

   function automatic mdl_t step(input mdl_t c, input logic ng, input logic en,
                                 input logic rr, input logic [1:0] col, input logic rdy);
      mdl_t n = c;
      if (ng) begin
         n = '0;
      end else if (c.pend) begin
         if (rdy) begin
            n.pend     = 1'b0;
            n.steps    = 0;
            n.player   = (c.player + 1) % NP;
            n.clearing = 1'b1;
            n.none_run = 0;
         end
      end else if (c.clearing) begin
         if (rr) begin
            if (int'(col) == 0) begin
               n.none_run = c.none_run + 1;
               if (n.none_run == CLR) begin
                  n.clearing = 1'b0;
                  n.none_run = 0;
               end
            end else begin
               n.none_run = 0;
            end
         end
      end else if (!en) begin
         n.run_len = 0;
      end else if (rr) begin
         if (int'(col) == 0) n.run_len = 0;
         else if (c.run_len > 0 && int'(col) == c.run_col) n.run_len = c.run_len + 1;
         else begin
            n.run_col = int'(col);
            n.run_len = 1;
         end
         if (n.run_len == CONF) begin
            n.pend    = 1'b1;
            n.steps   = n.run_col;
            n.run_len = 0;
         end
      end
      return n;
   endfunction

   function automatic int exp_dbg(input mdl_t c);
      if (c.pend)          return int'(S_ISSUE);
      if (c.clearing)      return int'(S_WAIT_CLEAR);
      if (c.run_len > 0)   return int'(S_CONFIRM);
      return int'(S_ARMED);
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) m <= '0;
      else       m <= step(m, new_game, roll_enable, result_ready, stable_color, move_ready);
   end

   always @(posedge clk) begin
      if (!reset && move_valid && move_ready) xfers <= xfers + 1;
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      check("m_valid", int'(move_valid), int'(m.pend));
      check("m_steps", int'(move_steps), m.pend ? m.steps : 0);
      check("m_armed", int'(armed), int'(!m.pend && !m.clearing && m.run_len == 0));
      check("m_dbg", int'(dbg_state), exp_dbg(m));
      if (m.pend) check("m_player", int'(move_player), m.player);
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // n result pulses of one colour, one idle cycle before each; returns one
   // negedge after the last pulse was sampled
   task automatic roll(input logic [1:0] c, input int n);
      repeat (n) begin
         idle(1);
         stable_color = c;
         result_ready = 1'b1;
         @(negedge clk);
         result_ready = 1'b0;
         stable_color = 2'd0;
      end
   endtask

   initial begin
      idle(3);
      reset = 1'b0;
      check("rst_valid", int'(move_valid), 0);
      check("rst_steps", int'(move_steps), 0);
      check("rst_player", int'(move_player), 0);
      check("rst_armed", int'(armed), 1);
      check("rst_dbg", int'(dbg_state), 0);

      // 1: RED x4 with ready high -> single-cycle move, steps 1, player 0
      roll(2'd1, 4);
      check("t1_valid", int'(move_valid), 1);
      check("t1_steps", int'(move_steps), 1);
      check("t1_player", int'(move_player), 0);
      idle(1);
      check("t1_pulse", int'(move_valid), 0);
      check("t1_wait", int'(dbg_state), 3);
      roll(2'd0, 3);
      check("t1_rearm", int'(armed), 1);

      // 2: NONE aborts a confirm; then colour change restarts the count
      roll(2'd1, 2);
      roll(2'd0, 1);
      check("t2_abort_armed", int'(armed), 1);
      check("t2_abort_valid", int'(move_valid), 0);
      roll(2'd2, 2);
      roll(2'd3, 3);
      check("t2_early", int'(move_valid), 0);
      roll(2'd3, 1);
      check("t2_valid", int'(move_valid), 1);
      check("t2_steps", int'(move_steps), 3);
      check("t2_player", int'(move_player), 1);
      idle(1);
      roll(2'd0, 3);

      // 3: back-pressure holds the command for 10 cycles
      move_ready = 1'b0;
      roll(2'd3, 4);
      repeat (10) begin
         check("t3_hold_valid", int'(move_valid), 1);
         check("t3_hold_steps", int'(move_steps), 3);
         check("t3_hold_player", int'(move_player), 0);
         idle(1);
      end
      move_ready = 1'b1;
      idle(1);
      check("t3_done", int'(move_valid), 0);

      // 4: card lingering blocks re-arm until three NONEs in a row
      roll(2'd1, 5);
      roll(2'd0, 2);
      roll(2'd1, 1);
      roll(2'd0, 2);
      check("t4_not_armed", int'(armed), 0);
      roll(2'd0, 1);
      check("t4_armed", int'(armed), 1);
      roll(2'd2, 4);
      check("t4_valid", int'(move_valid), 1);
      check("t4_steps", int'(move_steps), 2);
      check("t4_player", int'(move_player), 1);
      idle(1);
      roll(2'd0, 3);

      // 5: roll_enable gating
      roll_enable = 1'b0;
      roll(2'd1, 4);
      check("t5_gated_valid", int'(move_valid), 0);
      check("t5_gated_armed", int'(armed), 1);
      roll_enable = 1'b1;
      roll(2'd1, 2);
      check("t5_confirm", int'(dbg_state), 1);
      roll_enable = 1'b0;
      idle(1);
      check("t5_drop", int'(dbg_state), 0);
      roll_enable = 1'b1;
      roll(2'd1, 2);
      check("t5_recount_valid", int'(move_valid), 0);
      check("t5_recount_dbg", int'(dbg_state), 1);
      roll(2'd1, 2);
      check("t5_valid", int'(move_valid), 1);
      check("t5_player_wrap", int'(move_player), 0);
      idle(1);
      roll(2'd0, 3);

      // 6: new_game and async reset during ISSUE
      move_ready = 1'b0;
      roll(2'd3, 4);
      check("t6_valid", int'(move_valid), 1);
      check("t6_player", int'(move_player), 1);
      new_game = 1'b1;
      idle(1);
      new_game = 1'b0;
      check("t6_ng_valid", int'(move_valid), 0);
      check("t6_ng_armed", int'(armed), 1);
      roll(2'd3, 4);
      check("t6_ng_player", int'(move_player), 0);
      #2 reset = 1'b1;
      #1;
      check("t6_rst_valid", int'(move_valid), 0);
      check("t6_rst_steps", int'(move_steps), 0);
      check("t6_rst_armed", int'(armed), 1);
      check("t6_rst_dbg", int'(dbg_state), 0);
      idle(2);
      #2 reset = 1'b0;
      move_ready = 1'b1;
      idle(2);
      check("t6_no_move", int'(move_valid), 0);
      roll(2'd1, 4);
      check("t6_after_valid", int'(move_valid), 1);
      check("t6_after_player", int'(move_player), 0);
      idle(1);

      check("xfer_count", xfers, 6);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
